step_pulse_gen: RTL and testbench
=================================

// Module: step_pulse_gen
// PURPOSE
//  Upstream motion stage for the stepper phase driver. Accepts move commands
//  (direction, step count, step period) over a valid/ready handshake and emits
//  clean step/dir signals with guaranteed dir setup time and minimum pulse width.
//  The step output feeds the phase driver, which advances its phase counter on
//  each rising edge of step.
// PARAMETERS
//  CNT_W            32  width of step count, period and internal timers
//  STEP_HIGH_TICKS   8  clocks step is held high per pulse (>=1)
//  DIR_SETUP_TICKS   4  clocks from dir update to first step rise (>=1)
// PORTS
//  clk              in   1      system clock
//  resetn           in   1      asynchronous active-low reset
//  cmd_valid        in   1      move command present
//  cmd_ready        out  1      block can accept a command (high only in IDLE)
//  cmd_dir          in   1      move direction, copied to dir
//  cmd_steps        in   CNT_W  number of step pulses to emit
//  cmd_period       in   CNT_W  clocks between step rising edges
//  abort            in   1      stop current move at next safe point
//  step             out  1      step pulse to phase driver
//  dir              out  1      direction to phase driver
//  busy             out  1      high whenever state != IDLE
//  move_done        out  1      one-cycle pulse when a move completes or aborts
//  steps_remaining  out  CNT_W  steps not yet started in current move
// BEHAVIOUR
//  Reset (resetn low, async): state=IDLE, step=0, dir=0, busy=0, move_done=0,
//   steps_remaining=0, cmd_ready=1. Reset mid-move drops step at once; no resume.
//  FSM states: IDLE, DIR_SETUP, STEP_HIGH, STEP_LOW. All outputs are registered
//   except cmd_ready and busy, which are decoded from state.
//  Accept: cmd_valid & cmd_ready at edge N. cmd_steps==0: stay IDLE, move_done=1
//   for the cycle after N, no step, dir unchanged. Otherwise at N: dir<=cmd_dir,
//   steps_remaining<=cmd_steps, latch period, go DIR_SETUP.
//  Effective period P = max(cmd_period, 2*STEP_HIGH_TICKS), clamp computed at accept.
//  DIR_SETUP: DIR_SETUP_TICKS cycles (always, even if dir unchanged) -> STEP_HIGH.
//   First step rise occurs DIR_SETUP_TICKS clocks after N.
//  STEP_HIGH: step=1 for exactly STEP_HIGH_TICKS cycles; steps_remaining
//   decrements by 1 on entry. -> STEP_LOW.
//  STEP_LOW: step=0 for P-STEP_HIGH_TICKS cycles. Then: steps_remaining!=0 and no
//   abort pending -> STEP_HIGH. Otherwise -> IDLE with move_done=1 on that edge.
//   Consecutive rising edges are exactly P clocks apart.
//  dir never changes while busy; it changes only at command accept.
//  abort (level, sampled each clock): IDLE ignored (a cmd_valid in the same cycle
//   is accepted). DIR_SETUP -> IDLE next edge with move_done, no step emitted.
//   STEP_HIGH: pulse completes its full width (no runt), then STEP_LOW is skipped
//   -> IDLE with move_done. STEP_LOW -> IDLE next edge with move_done.
//   steps_remaining holds its value after abort.
//  Timers count down and never wrap; cmd_steps up to 2^CNT_W-1 supported.
//  Back-to-back: cmd_ready rises the cycle move_done is asserted; a new command
//   may be accepted at that edge, restarting DIR_SETUP.
// TESTING
//  1. steps=3, period=20, dir=1 (defaults) -> dir=1 at accept, step rises at
//     +4, +24, +44 clocks, each 8 clocks high, move_done at +64, steps_remaining=0.
//  2. steps=0 -> move_done one cycle after accept, step stays 0, busy stays 0.
//  3. period=5 -> clamped to 16: rising edges 16 clocks apart, 8 high / 8 low.
//  4. steps=10, period=20, abort pulsed 2 clocks into 3rd high -> pulse stays high
//     full 8 clocks, then IDLE + move_done, steps_remaining=7, no further pulses.
//  5. resetn low for 1 clock during STEP_HIGH of a 5-step move -> step=0
//     immediately, all outputs at reset values, no pulses after release.
//  6. cmd_valid held with dir 1 then 0 back-to-back, steps=2 each -> second
//     command accepted on move_done edge; dir flips there, next step rise exactly
//     4 clocks later; total 4 pulses.

Source files
------------

// File: rtl/step_pulse_gen.sv
// Step/dir pulse generator for the stepper phase driver.
// Accepts move commands over valid/ready and emits step pulses with a fixed
// high width and a programmable rise-to-rise period. The block guarantees a
// dir setup time before the first step, and abort never produces a runt pulse.
module step_pulse_gen #(
   parameter int CNT_W           = 32,
   parameter int STEP_HIGH_TICKS = 8,
   parameter int DIR_SETUP_TICKS = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_dir,
   input  logic [CNT_W-1:0] cmd_steps,
   input  logic [CNT_W-1:0] cmd_period,
   input  logic             abort,
   output logic             step,
   output logic             dir,
   output logic             busy,
   output logic             move_done,
   output logic [CNT_W-1:0] steps_remaining
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SETUP = 2'd1;
   localparam logic [1:0] S_HIGH  = 2'd2;
   localparam logic [1:0] S_LOW   = 2'd3;

   // Timer reload values are "ticks - 1" because each timer runs until it reads zero.
   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(DIR_SETUP_TICKS - 1);
   localparam logic [CNT_W-1:0] HIGH_LD  = CNT_W'(STEP_HIGH_TICKS - 1);
   localparam logic [CNT_W-1:0] HIGH_T   = CNT_W'(STEP_HIGH_TICKS);
   localparam logic [CNT_W-1:0] MIN_P    = CNT_W'(2 * STEP_HIGH_TICKS);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] tmr_q, tmr_d;
   logic [CNT_W-1:0] low_ld_q, low_ld_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic             step_q, step_d;
   logic             dir_q, dir_d;
   logic             done_q, done_d;
   logic             pend_q, pend_d;
   logic [CNT_W-1:0] period_eff;

   // Period clamp keeps the low phase at least as long as the high phase.
   always_comb begin
      period_eff = (cmd_period > MIN_P) ? cmd_period : MIN_P;
   end

   // Next-state logic for the move sequencer.
   always_comb begin
      state_d  = state_q;
      tmr_d    = tmr_q;
      low_ld_d = low_ld_q;
      rem_d    = rem_q;
      step_d   = step_q;
      dir_d    = dir_q;
      done_d   = 1'b0;
      pend_d   = pend_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               if (cmd_steps == '0) begin
                  done_d = 1'b1;
               end else begin
                  dir_d    = cmd_dir;
                  rem_d    = cmd_steps;
                  low_ld_d = period_eff - HIGH_T - ONE;
                  tmr_d    = SETUP_LD;
                  pend_d   = 1'b0;
                  state_d  = S_SETUP;
               end
            end
         end
         S_SETUP: begin
            if (abort) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else if (tmr_q == '0) begin
               state_d = S_HIGH;
               tmr_d   = HIGH_LD;
               step_d  = 1'b1;
               rem_d   = rem_q - ONE;
            end else begin
               tmr_d = tmr_q - ONE;
            end
         end
         S_HIGH: begin
            // Abort is deferred until the pulse has its full width.
            if (tmr_q == '0) begin
               step_d = 1'b0;
               if (pend_q || abort) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
                  pend_d  = 1'b0;
               end else begin
                  state_d = S_LOW;
                  tmr_d   = low_ld_q;
               end
            end else begin
               tmr_d = tmr_q - ONE;
               if (abort) pend_d = 1'b1;
            end
         end
         default: begin
            if (abort) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else if (tmr_q == '0) begin
               if (rem_q != '0) begin
                  state_d = S_HIGH;
                  tmr_d   = HIGH_LD;
                  step_d  = 1'b1;
                  rem_d   = rem_q - ONE;
               end else begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end else begin
               tmr_d = tmr_q - ONE;
            end
         end
      endcase
   end

   // State and registered outputs; reset drops step immediately.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= S_IDLE;
         tmr_q    <= '0;
         low_ld_q <= '0;
         rem_q    <= '0;
         step_q   <= 1'b0;
         dir_q    <= 1'b0;
         done_q   <= 1'b0;
         pend_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         tmr_q    <= tmr_d;
         low_ld_q <= low_ld_d;
         rem_q    <= rem_d;
         step_q   <= step_d;
         dir_q    <= dir_d;
         done_q   <= done_d;
         pend_q   <= pend_d;
      end
   end

   // Handshake and status decoded straight from state.
   always_comb begin
      cmd_ready       = (state_q == S_IDLE);
      busy            = (state_q != S_IDLE);
      step            = step_q;
      dir             = dir_q;
      move_done       = done_q;
      steps_remaining = rem_q;
   end

endmodule

// File: tb/tb_step_pulse_gen.sv
// Self-checking bench for step_pulse_gen: a timeline model predicts every
// output each cycle from the move's accept time, step count and period.
module tb_step_pulse_gen;

   localparam int SH = 8;
   localparam int DS = 4;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_dir = 1'b0;
   logic [31:0] cmd_steps = '0;
   logic [31:0] cmd_period = '0;
   logic        abort = 1'b0;
   logic        step, dir, busy, move_done;
   logic [31:0] steps_remaining;

   step_pulse_gen dut (
      .clk             (clk),
      .resetn          (resetn),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_dir         (cmd_dir),
      .cmd_steps       (cmd_steps),
      .cmd_period      (cmd_period),
      .abort           (abort),
      .step            (step),
      .dir             (dir),
      .busy            (busy),
      .move_done       (move_done),
      .steps_remaining (steps_remaining)
   );

   always #5 clk = ~clk;

   int     n_pass = 0;
   int     n_total = 0;
   longint cyc = 0;

   // Model state: a move is described by its accept cycle, step count and period.
   bit     m_busy, m_dir, m_done, m_step, m_pend;
   longint m_rem, m_t0, m_S, m_P, acc_cyc;

   // Observation log (absolute cycles).
   longint rises[$];
   longint done_at;
   bit     prev_step;

   function automatic void chk(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
   endfunction

   function automatic void model_reset();
      m_busy = 0; m_dir = 0; m_done = 0; m_step = 0; m_rem = 0; m_pend = 0;
   endfunction

   // Predict outputs just after edge 'cyc' from the inputs sampled at that edge.
   function automatic void model_edge();
      longint e, q;
      bit     fin;
      m_done = 0;
      if (!resetn) begin
         model_reset();
         return;
      end
      if (!m_busy) begin
         m_step = 0;
         if (cmd_valid) begin
            acc_cyc = cyc;
            if (cmd_steps == 0) begin
               m_done = 1;
            end else begin
               m_busy = 1;
               m_dir  = cmd_dir;
               m_S    = longint'({32'b0, cmd_steps});
               m_rem  = m_S;
               m_P    = longint'({32'b0, cmd_period});
               if (m_P < 2 * SH) m_P = 2 * SH;
               m_t0   = cyc;
               m_pend = 0;
            end
         end
      end else begin
         e   = cyc - m_t0;
         fin = 0;
         if (e <= DS) begin
            if (abort) fin = 1;
         end else begin
            q = (e - DS - 1) % m_P;  // phase within the period before this edge
            if (q < SH) begin
               if (abort) m_pend = 1;
               if (q + 1 == SH && m_pend) fin = 1;
            end else if (abort) begin
               fin = 1;
            end
         end
         if (!fin && e - DS == m_S * m_P) fin = 1;
         if (fin) begin
            m_busy = 0; m_done = 1; m_step = 0;
         end else if (e >= DS) begin
            m_step = ((e - DS) % m_P) < SH;
            m_rem  = m_S - ((e - DS) / m_P + 1);
         end
      end
   endfunction

   function automatic void compare();
      chk("cmd_ready", cmd_ready, !m_busy);
      chk("busy", busy, m_busy);
      chk("step", step, m_step);
      chk("dir", dir, m_dir);
      chk("move_done", move_done, m_done);
      chk("steps_remaining", steps_remaining, m_rem & 64'hFFFF_FFFF);
   endfunction

   task automatic tick();
      @(posedge clk);
      cyc++;
      model_edge();
      #1;
      compare();
      if (step && !prev_step) rises.push_back(cyc);
      if (move_done) done_at = cyc;
      prev_step = step;
   endtask

   task automatic issue(input bit d, input int unsigned s, input int unsigned p);
      rises.delete();
      done_at   = -1;
      cmd_valid = 1; cmd_dir = d; cmd_steps = s; cmd_period = p;
      tick();
      cmd_valid = 0;
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (move_done) return;
         tick();
      end
      if (!move_done) chk("timeout", 0, 1);
   endtask

   task automatic run_to(input longint off);
      for (int i = 0; i < 1000 && cyc - acc_cyc < off; i++) tick();
   endtask

   longint a1;

   initial begin
      model_reset();
      acc_cyc = 0; done_at = -1; prev_step = 0;
      tick(); tick();
      resetn = 1;
      tick();

      // 1: basic 3-step move.
      issue(1, 3, 20);
      a1 = acc_cyc;
      wait_done(200);
      chk("t1_npulses", rises.size(), 3);
      if (rises.size() == 3) begin
         chk("t1_rise0", rises[0] - a1, 4);
         chk("t1_rise1", rises[1] - a1, 24);
         chk("t1_rise2", rises[2] - a1, 44);
      end
      chk("t1_done", done_at - a1, 64);
      chk("t1_rem", steps_remaining, 0);
      chk("t1_dir", dir, 1);
      tick();

      // 2: zero-step command completes at once, dir unchanged.
      issue(0, 0, 20);
      chk("t2_done", done_at - acc_cyc, 0);
      chk("t2_busy", busy, 0);
      tick(); tick();
      chk("t2_npulses", rises.size(), 0);
      chk("t2_dir", dir, 1);

      // 3: period clamp.
      issue(1, 2, 5);
      a1 = acc_cyc;
      wait_done(200);
      chk("t3_npulses", rises.size(), 2);
      if (rises.size() == 2) chk("t3_spacing", rises[1] - rises[0], 16);
      chk("t3_done", done_at - a1, 36);
      tick();

      // 4: abort two clocks into the third high phase.
      issue(0, 10, 20);
      a1 = acc_cyc;
      run_to(45);
      abort = 1;
      tick();
      abort = 0;
      wait_done(200);
      chk("t4_done", done_at - a1, 52);
      chk("t4_rem", steps_remaining, 7);
      for (int i = 0; i < 40; i++) tick();
      chk("t4_npulses", rises.size(), 3);

      // 5: reset pulse in the middle of a high phase.
      issue(1, 5, 20);
      run_to(30);
      chk("t5_step_before", step, 1);
      resetn = 0;
      model_reset();
      #1;
      chk("t5_step_now", step, 0);
      chk("t5_dir_now", dir, 0);
      chk("t5_rem_now", steps_remaining, 0);
      tick();
      resetn = 1;
      for (int i = 0; i < 60; i++) tick();
      chk("t5_npulses", rises.size(), 2);

      // 6: back-to-back commands with cmd_valid held.
      rises.delete();
      cmd_valid = 1; cmd_dir = 1; cmd_steps = 2; cmd_period = 20;
      tick();
      a1 = acc_cyc;
      cmd_dir = 0;
      wait_done(200);
      tick();
      cmd_valid = 0;
      chk("t6_acc2", acc_cyc - a1, 45);
      chk("t6_dir", dir, 0);
      wait_done(200);
      chk("t6_npulses", rises.size(), 4);
      if (rises.size() == 4) begin
         chk("t6_rise2", rises[2] - acc_cyc, 4);
         chk("t6_rise3", rises[3] - acc_cyc, 24);
      end
      tick();

      // Randomised traffic checked cycle by cycle against the model.
      for (int i = 0; i < 6000; i++) begin
         int unsigned sel;
         cmd_valid = ($urandom_range(0, 3) != 0);
         cmd_dir   = 1'($urandom_range(0, 1));
         sel       = $urandom_range(0, 7);
         cmd_steps = (sel == 0) ? 32'd0 : (sel == 1) ? 32'hFFFF_FFFE : $urandom_range(1, 4);
         sel       = $urandom_range(0, 9);
         cmd_period = (sel < 7) ? $urandom_range(0, 40) : (sel == 8) ? 32'hFFFF_FFF0 : 32'd16;
         abort     = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 1499) == 0) begin
            resetn = 0;
            model_reset();
            tick();
            resetn = 1;
         end else begin
            tick();
         end
      end
      cmd_valid = 0;
      abort = 0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
